// File: rtl/accum_write_if.sv
// accum_write_if: bundles the accumulation write controller's config, psum stream, bank strobes and bank-switch handshake.
// master: psum source / main FSM side; slave: accum_write_fsm side.
`timescale 1ns/1ps
interface accum_write_if #(
  parameter int ADDR_W = 8,
  parameter int PASS_W = 16
);
  logic              config_en;
  logic [ADDR_W-1:0] config_depth_m1;
  logic [PASS_W-1:0] config_passes_m1;
  logic              psum_valid;
  logic              psum_ready;
  logic              acc_ren;
  logic [ADDR_W-1:0] acc_raddr;
  logic              acc_wen;
  logic [ADDR_W-1:0] acc_waddr;
  logic              acc_first;
  logic              write_bank_done;
  logic              write_bank_ready_to_switch;
  logic              ready_to_switch;
  logic              start_new_write_bank;
  modport master (
    output config_en, config_depth_m1, config_passes_m1, psum_valid,
           ready_to_switch, start_new_write_bank,
    input  psum_ready, acc_ren, acc_raddr, acc_wen, acc_waddr, acc_first,
           write_bank_done, write_bank_ready_to_switch
  );
  modport slave (
    input  config_en, config_depth_m1, config_passes_m1, psum_valid,
           ready_to_switch, start_new_write_bank,
    output psum_ready, acc_ren, acc_raddr, acc_wen, acc_waddr, acc_first,
           write_bank_done, write_bank_ready_to_switch
  );
endinterface

// File: rtl/accum_write_fsm.sv
// accum_write_fsm: write-side read-modify-write controller that accumulates each bank word over all passes.
// Ports: clk, rst_n (sync, active-low); bus (slave) carries config, psum handshake, read/write strobes,
// bank-done pulse and the ready-to-switch / start-new-bank handshake with the main FSM.
`timescale 1ns/1ps
module accum_write_fsm #(
  parameter int ADDR_W = 8,
  parameter int PASS_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  accum_write_if.slave bus
);
  typedef enum logic [2:0] {RESET, WAIT_START, ACCUM, DRAIN, DONE, WAIT_SWITCH} state_t;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt, depth_m1, wr_addr;
  logic [PASS_W-1:0] pass_cnt, passes_m1;
  logic              wr_pend, wr_first, accept, hazard, last_word, wrap, cfg_ok;
  always_comb begin
    // With a single-word bank the next pass would read the word still being written; stall one cycle.
    hazard = wr_pend && wr_addr == addr_cnt;
    bus.psum_ready = state == ACCUM && !hazard;
    accept = bus.psum_valid && bus.psum_ready;
    wrap = addr_cnt == depth_m1;
    last_word = wrap && pass_cnt == passes_m1;
    cfg_ok = bus.config_en && (state == RESET || state == WAIT_START);
    bus.acc_ren = accept && pass_cnt != '0;
    bus.acc_raddr = addr_cnt;
    bus.acc_wen = wr_pend;
    bus.acc_waddr = wr_addr;
    bus.acc_first = wr_first;
    bus.write_bank_done = state == DONE;
    bus.write_bank_ready_to_switch = state == WAIT_SWITCH;
    state_nxt = state;
    case (state)
      RESET:       state_nxt = WAIT_START;
      WAIT_START:  state_nxt = bus.start_new_write_bank ? ACCUM : WAIT_START;
      ACCUM:       state_nxt = accept && last_word ? DRAIN : ACCUM;
      DRAIN:       state_nxt = DONE;
      DONE:        state_nxt = WAIT_SWITCH;
      WAIT_SWITCH: state_nxt = bus.ready_to_switch ? WAIT_START : WAIT_SWITCH;
      default:     state_nxt = RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RESET;
      addr_cnt <= '0;
      pass_cnt <= '0;
      depth_m1 <= '0;
      passes_m1 <= '0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_first <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_ok) begin
        depth_m1 <= bus.config_depth_m1;
        passes_m1 <= bus.config_passes_m1;
      end
      if (state == WAIT_START && bus.start_new_write_bank) begin
        addr_cnt <= '0;
        pass_cnt <= '0;
      end else if (accept) begin
        addr_cnt <= wrap ? '0 : addr_cnt + 1'b1;
        pass_cnt <= wrap ? pass_cnt + 1'b1 : pass_cnt;
      end
      wr_pend <= accept;
      if (accept) begin
        wr_addr <= addr_cnt;
        wr_first <= pass_cnt == '0;
      end
    end
  end
endmodule

// File: tb/tb_accum_write_fsm.sv
// tb_accum_write_fsm: table-driven bank runs with a write scoreboard, plus handshake, reset and config corner cases.
`timescale 1ns/1ps
module tb_accum_write_fsm;
  typedef struct {int n_m1; int p_m1; int gap; int exp_acc; int exp_first; int exp_span;} vec_t;
  typedef struct {int addr; int first;} wr_t;
  logic clk = 1'b0;
  logic rst_n;
  accum_write_if #(.ADDR_W(8), .PASS_W(16)) bus ();
  accum_write_fsm #(.ADDR_W(8), .PASS_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc, n_wr, n_first, first_acc, last_acc, done_cyc, rst_at;
  int m_addr, m_pass, m_n_m1;
  int s_ready, s_ren, s_raddr, s_wen, s_waddr, s_first, s_done, s_rts;
  wr_t sb[$];
  vec_t vecs[5];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_start(input int n_m1);
    n_acc = 0; n_wr = 0; n_first = 0;
    first_acc = -1; last_acc = -1; done_cyc = -1;
    m_addr = 0; m_pass = 0; m_n_m1 = n_m1;
    sb.delete();
  endtask
  task automatic tick();
    wr_t e;
    @(negedge clk);
    s_ready = bus.psum_ready; s_ren = bus.acc_ren; s_raddr = bus.acc_raddr;
    s_wen = bus.acc_wen; s_waddr = bus.acc_waddr; s_first = bus.acc_first;
    s_done = bus.write_bank_done; s_rts = bus.write_bank_ready_to_switch;
    if (bus.acc_wen) begin
      n_wr++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got waddr %0d with no pending accept", bus.acc_waddr);
      end else begin
        e = sb.pop_front();
        chk("waddr", bus.acc_waddr, e.addr);
        chk("acc_first", bus.acc_first, e.first);
        if (bus.acc_first) n_first++;
      end
    end
    if (bus.psum_valid && bus.psum_ready) begin
      chk("acc_ren", bus.acc_ren, m_pass != 0);
      chk("acc_raddr", bus.acc_raddr, m_addr);
      sb.push_back('{m_addr, int'(m_pass == 0)});
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      n_acc++;
      if (m_addr == m_n_m1) begin m_addr = 0; m_pass++; end
      else m_addr++;
    end else chk("ren_idle", bus.acc_ren, 0);
    if (bus.acc_ren && bus.acc_wen && bus.acc_raddr == bus.acc_waddr) begin
      checks++; errors++;
      $display("FAIL rw_hazard: read and write both at address %0d", bus.acc_raddr);
    end
    if (bus.write_bank_done && done_cyc < 0) done_cyc = cyc;
    if (rst_at > 0 && n_acc == rst_at) begin rst_n = 1'b0; rst_at = 0; end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, s_ready, 0); chk({tag, "_ren"}, s_ren, 0);
    chk({tag, "_raddr"}, s_raddr, 0); chk({tag, "_wen"}, s_wen, 0);
    chk({tag, "_waddr"}, s_waddr, 0); chk({tag, "_first"}, s_first, 0);
    chk({tag, "_done"}, s_done, 0); chk({tag, "_rts"}, s_rts, 0);
  endtask
  task automatic run_bank(input vec_t v, input bit do_cfg, input int cfg_pulse);
    int budget;
    model_start(v.n_m1);
    if (do_cfg) begin
      bus.config_en = 1'b1;
      bus.config_depth_m1 = 8'(v.n_m1);
      bus.config_passes_m1 = 16'(v.p_m1);
    end
    bus.start_new_write_bank = 1'b1;
    bus.psum_valid = 1'b0;
    tick();
    bus.config_en = 1'b0;
    bus.start_new_write_bank = 1'b0;
    budget = 0;
    while (done_cyc < 0 && budget < 400) begin
      bus.psum_valid = $urandom_range(99) >= v.gap;
      bus.config_en = cfg_pulse > 0 && n_acc == cfg_pulse;
      if (bus.config_en) begin bus.config_depth_m1 = 8'd1; cfg_pulse = 0; end
      tick();
      budget++;
    end
    bus.psum_valid = 1'b0;
    bus.config_en = 1'b0;
    chk("bank_done_seen", done_cyc >= 0, 1);
    chk("accepts", n_acc, v.exp_acc);
    chk("writes", n_wr, v.exp_acc);
    chk("first_writes", n_first, v.exp_first);
    chk("done_latency", done_cyc - last_acc, 2);
    if (v.exp_span >= 0) chk("accept_span", last_acc - first_acc, v.exp_span);
    chk("rts_in_done", s_rts, 0);
    tick();
    chk("rts_after_done", s_rts, 1);
    chk("done_pulse_len", s_done, 0);
  endtask
  task automatic do_switch();
    bus.ready_to_switch = 1'b1;
    tick();
    chk("rts_before_switch", s_rts, 1);
    bus.ready_to_switch = 1'b0;
    tick();
    chk("rts_after_switch", s_rts, 0);
    chk("sb_drained", sb.size(), 0);
  endtask
  initial begin
    vecs[0] = '{3, 2, 0, 12, 4, 11};
    vecs[1] = '{0, 3, 0, 4, 1, 6};
    vecs[2] = '{7, 1, 40, 16, 8, -1};
    vecs[3] = '{0, 0, 0, 1, 1, 0};
    vecs[4] = '{4, 0, 0, 5, 5, 4};
    rst_n = 1'b0; rst_at = 0;
    bus.config_en = 1'b0; bus.config_depth_m1 = '0; bus.config_passes_m1 = '0;
    bus.psum_valid = 1'b0; bus.ready_to_switch = 1'b0; bus.start_new_write_bank = 1'b0;
    model_start(0);
    @(posedge clk); #1;
    tick();
    bus.psum_valid = 1'b1;
    tick();
    chk_zero("reset");
    chk("reset_no_accept", n_acc, 0);
    bus.psum_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      run_bank(vecs[i], 1'b1, 0);
      do_switch();
    end
    run_bank('{3, 1, 0, 8, 4, 7}, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rts_hold", s_rts, 1);
    end
    bus.ready_to_switch = 1'b1;
    bus.start_new_write_bank = 1'b1;
    tick();
    bus.ready_to_switch = 1'b0;
    bus.start_new_write_bank = 1'b0;
    bus.psum_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_not_ready", s_ready, 0);
      chk("idle_rts", s_rts, 0);
    end
    chk("idle_no_accept", n_acc, 8);
    bus.psum_valid = 1'b0;
    run_bank('{3, 1, 0, 8, 4, 7}, 1'b0, 0);
    do_switch();
    run_bank('{3, 1, 0, 8, 4, 7}, 1'b1, 3);
    do_switch();
    model_start(3);
    bus.config_en = 1'b1; bus.config_depth_m1 = 8'd3; bus.config_passes_m1 = 16'd1;
    bus.start_new_write_bank = 1'b1;
    tick();
    bus.config_en = 1'b0; bus.start_new_write_bank = 1'b0;
    bus.psum_valid = 1'b1;
    rst_at = 6;
    for (int i = 0; i < 20 && rst_n; i++) tick();
    chk("reset_at_accept", n_acc, 6);
    tick();
    chk_zero("midreset");
    sb.delete();
    bus.psum_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    run_bank('{3, 1, 0, 8, 4, 7}, 1'b1, 0);
    do_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
